// File: rtl/niosii_system_sysid_ext.sv
// rtl/niosii_system_sysid_ext.sv - sysid slave with uptime counter, scratch, ctrl and feature words
// Optional uptime counter/snapshot enabled by `define NIOSII_SYSID_UPTIME_EN.
module niosii_system_sysid_ext #(
  parameter logic [31:0] SYSTEM_ID     = 32'h0000_CAFE,
  parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
  parameter int          SCRATCH_COUNT = 2,
  parameter int          READ_LATENCY  = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [3:0] SC_FIELD  = 4'(SCRATCH_COUNT);
  localparam logic [1:0] LAT_FIELD = 2'(READ_LATENCY);
`ifdef NIOSII_SYSID_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif
  localparam logic [31:0] FEATURES = {23'd0, UPTIME_PRESENT, 2'd0, LAT_FIELD, SC_FIELD};

  logic        freeze;
  logic [31:0] scratch [2];
  logic [31:0] uptime_lo;
  logic [31:0] uptime_hi;
  logic [31:0] rd_mux;
  logic        s1_valid;
  logic [31:0] s1_data;
  logic        ctrl_wr;
  logic        scratch_ok;

  assign ctrl_wr    = write && (address == 3'd6);
  // Words 6/7 always belong to CTRL/FEATURES, so only words 4 and 5 can hold scratch.
  assign scratch_ok = (SCRATCH_COUNT > 1) || !address[0];

`ifdef NIOSII_SYSID_UPTIME_EN
  logic [63:0] counter;
  logic [31:0] snapshot;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter  <= 64'd0;
      snapshot <= 32'd0;
    end else begin
      if (ctrl_wr && writedata[1])
        counter <= 64'd0;
      else if (!freeze)
        counter <= counter + 64'd1;
      if (read && (address == 3'd2))
        snapshot <= counter[63:32];
    end
  end

  assign uptime_lo = counter[31:0];
  assign uptime_hi = snapshot;
`else
  assign uptime_lo = 32'd0;
  assign uptime_hi = 32'd0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      freeze     <= 1'b0;
      scratch[0] <= 32'd0;
      scratch[1] <= 32'd0;
    end else if (write) begin
      if (ctrl_wr)
        freeze <= writedata[0];
      if ((address[2:1] == 2'b10) && scratch_ok)
        scratch[address[0]] <= writedata;
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (address)
      3'd0: rd_mux = SYSTEM_ID;
      3'd1: rd_mux = TIMESTAMP;
      3'd2: rd_mux = uptime_lo;
      3'd3: rd_mux = uptime_hi;
      3'd4: rd_mux = scratch[0];
      3'd5: rd_mux = scratch_ok ? scratch[1] : 32'd0;
      3'd6: rd_mux = {31'd0, freeze};
      3'd7: rd_mux = FEATURES;
      default: rd_mux = 32'd0;
    endcase
  end

  // Response pipeline; the output register is the last stage for either latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid      <= 1'b0;
      s1_data       <= 32'd0;
      readdatavalid <= 1'b0;
      readdata      <= 32'd0;
    end else begin
      s1_valid <= read;
      if (read)
        s1_data <= rd_mux;
      if (READ_LATENCY == 1) begin
        readdatavalid <= read;
        if (read)
          readdata <= rd_mux;
      end else begin
        readdatavalid <= s1_valid;
        if (s1_valid)
          readdata <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_niosii_system_sysid_ext.sv
// tb/tb_niosii_system_sysid_ext.sv - randomized and directed bench for niosii_system_sysid_ext
module tb_niosii_system_sysid_ext;

  localparam logic [31:0] SID = 32'h1234_5678;
  localparam logic [31:0] TS  = 32'h58C1_F58C;
  localparam int          SC  = 2;
  localparam int          LAT = 2;
`ifdef NIOSII_SYSID_UPTIME_EN
  localparam logic [31:0] FEAT = 32'h0000_0122;
`else
  localparam logic [31:0] FEAT = 32'h0000_0022;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int n_cmp = 0;
  int n_bad = 0;

  niosii_system_sysid_ext #(
    .SYSTEM_ID(SID), .TIMESTAMP(TS), .SCRATCH_COUNT(SC), .READ_LATENCY(LAT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;

  // Reference state
  logic [63:0] m_cnt;
  logic [31:0] m_snap;
  logic [31:0] m_scr [2];
  logic        m_frz;
  logic [32:0] pipe [$];
  logic        exp_v;
  logic [31:0] exp_d;
  logic [31:0] got_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 64'd0; m_snap = 32'd0; m_scr[0] = 32'd0; m_scr[1] = 32'd0; m_frz = 1'b0;
    pipe.delete();
    for (int i = 0; i < LAT - 1; i++) pipe.push_back(33'd0);
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return SID;
      3'd1: return TS;
`ifdef NIOSII_SYSID_UPTIME_EN
      3'd2: return m_cnt[31:0];
      3'd3: return m_snap;
`endif
      3'd4: return m_scr[0];
      3'd5: return (SC > 1) ? m_scr[1] : 32'd0;
      3'd6: return {31'd0, m_frz};
      3'd7: return FEAT;
      default: return 32'd0;
    endcase
  endfunction

  // One clock of bus activity: drive at negedge, advance an edge, check at the next negedge.
  task automatic step(input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] wd);
    logic [32:0] e;
    logic        clr;
    read = rd; write = wr; address = a; writedata = wd;
    if (!reset_n) begin
      model_reset();
      exp_v = 1'b0; exp_d = 32'd0;
    end else begin
      pipe.push_back({rd, model_read(a)});
      e = pipe.pop_front();
      exp_v = e[32]; exp_d = e[31:0];
      clr = wr && (a == 3'd6) && wd[1];
      if (rd && a == 3'd2) m_snap = m_cnt[63:32];
      if (clr) m_cnt = 64'd0;
      else if (!m_frz) m_cnt = m_cnt + 64'd1;
      if (wr && a == 3'd6) m_frz = wd[0];
      if (wr && a == 3'd4) m_scr[0] = wd;
      if (wr && a == 3'd5 && SC > 1) m_scr[1] = wd;
    end
    @(posedge clock);
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    check("rdv", 64'(readdatavalid), 64'(exp_v));
    if (exp_v) check("rdata", 64'(readdata), 64'(exp_d));
    if (!reset_n) check("rst_rdata", 64'(readdata), 64'd0);
    if (readdatavalid) got_q.push_back(readdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic rd_word(input logic [2:0] a);
    step(1'b1, 1'b0, a, 32'd0);
    idle(LAT - 1);
  endtask

  logic [31:0] lo1;

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    check("reset_rdv", 64'(readdatavalid), 64'd0);
    check("reset_rdata", 64'(readdata), 64'd0);

    got_q.delete();
    step(1'b1, 1'b0, 3'd0, 0); step(1'b1, 1'b0, 3'd1, 0); step(1'b1, 1'b0, 3'd7, 0); idle(LAT - 1);
    check("id", 64'(got_q[0]), 64'(SID));
    check("ts", 64'(got_q[1]), 64'(TS));
    check("features", 64'(got_q[2]), 64'(FEAT));

    step(1'b0, 1'b1, 3'd4, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 3'd5, 32'hA5A5_A5A5);
    step(1'b0, 1'b1, 3'd7, 32'hFFFF_FFFF);
    got_q.delete();
    step(1'b1, 1'b0, 3'd4, 0); step(1'b1, 1'b0, 3'd5, 0); step(1'b1, 1'b0, 3'd6, 0);
    step(1'b1, 1'b0, 3'd7, 0); idle(LAT - 1);
    check("scratch0", 64'(got_q[0]), 64'hDEAD_BEEF);
    check("scratch1", 64'(got_q[1]), 64'hA5A5_A5A5);
    check("ctrl0", 64'(got_q[2]), 64'd0);
    check("feat_ro", 64'(got_q[3]), 64'(FEAT));

    // Concurrent read and write to a scratch word returns the old value
    got_q.delete();
    step(1'b1, 1'b1, 3'd4, 32'h0BAD_F00D); idle(LAT - 1);
    check("rw_old", 64'(got_q[0]), 64'hDEAD_BEEF);

`ifdef NIOSII_SYSID_UPTIME_EN
    step(0, 1, 3'd6, 32'd1);
    step(0, 1, 3'd6, 32'd3);
    force dut.counter = 64'h0000_0001_FFFF_FFFE;
    idle(1);
    release dut.counter;
    m_cnt = 64'h0000_0001_FFFF_FFFE;
    step(0, 1, 3'd6, 32'd0);
    got_q.delete();
    rd_word(3'd2);
    idle(10);
    rd_word(3'd3);
    check("lo_pre", 64'(got_q[0]), 64'hFFFF_FFFE);
    check("hi_snap", 64'(got_q[1]), 64'h0000_0001);

    step(0, 1, 3'd6, 32'd1);
    got_q.delete();
    rd_word(3'd2);
    lo1 = got_q[$];
    idle(5);
    rd_word(3'd2);
    check("frozen_lo", 64'(got_q[$]), 64'(lo1));
    step(0, 1, 3'd6, 32'd2);
    idle(3);
    got_q.delete();
    rd_word(3'd2);
    check("clear_lo", 64'(got_q[0]), 64'd3);
`else
    got_q.delete();
    step(1'b1, 1'b0, 3'd2, 0); step(1'b1, 1'b0, 3'd3, 0); idle(LAT - 1);
    check("lo_absent", 64'(got_q[0]), 64'd0);
    check("hi_absent", 64'(got_q[1]), 64'd0);
    check("feat_bit8", 64'(FEAT[8]), 64'd0);
`endif

    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)), $urandom);

    // Reset the cycle after a read: the in-flight response must be dropped
    step(1'b0, 1'b1, 3'd5, 32'h1357_9BDF);
    step(1'b1, 1'b0, 3'd5, 0);
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    model_reset();
    check("post_rst_rdata", 64'(readdata), 64'd0);
    got_q.delete();
    step(1'b1, 1'b0, 3'd4, 0); step(1'b1, 1'b0, 3'd5, 0); idle(LAT - 1);
    check("post_rst_scr0", 64'(got_q[0]), 64'd0);
    check("post_rst_scr1", 64'(got_q[1]), 64'd0);
    check("post_rst_count", 64'(got_q.size()), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
